// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port synchronous memory between the CPU
//               datapath port and an external loader/debug (EXT) port. Grants
//               at most one access per clock, registers the memory command
//               and steers read data back to the owner through a two-stage
//               tag pipeline.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : AW      - address width
//               DW      - data width
//               AGE_LIM - denied EXT cycles before EXT is forced to win (1..15)
// Ports       : clock, reset (async, active-low)
//               cpu_*/ext_* req, wr, addr, wdata  - requester command inputs
//               ext_lock                          - EXT exclusive ownership
//               cpu_gnt/ext_gnt                   - combinational grants
//               cpu_rvalid/rdata, ext_rvalid/rdata - routed read return
//               mem_en, mem_we, mem_addr, mem_wdata - registered RAM command
//               mem_rdata                         - RAM read data
//               locked                            - high while EXT owns memory
// Build macro : MEM_ARB_AGING_EN - enables the EXT anti-starvation counter
// ============================================================================
module mem_port_arbiter #(
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int AGE_LIM = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          ext_req,
    input  logic          ext_wr,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    input  logic          ext_lock,
    output logic          cpu_gnt,
    output logic          ext_gnt,
    output logic          cpu_rvalid,
    output logic          ext_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          locked
);

    localparam logic [3:0] C_AGE_MAX = 4'(AGE_LIM);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t r_state;
    logic   w_cpu_gnt;
    logic   w_ext_gnt;
    logic   w_acc;
    logic   w_wr;
    logic   w_ext_force;
    logic   r_s1_rd;     // stage 1: command on the bus is a read
    logic   r_s1_ext;    // stage 1: command owner is EXT
    logic   r_s2_cpu;    // stage 2: RAM data this cycle belongs to CPU
    logic   r_s2_ext;    // stage 2: RAM data this cycle belongs to EXT

`ifdef MEM_ARB_AGING_EN
    logic [3:0] r_age_cnt;

    assign w_ext_force = ext_req && (r_age_cnt == C_AGE_MAX);

    // Counts cycles EXT waits; saturates so the force stays asserted until EXT wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_age_cnt <= 4'd0;
        end else if (ext_req && !w_ext_gnt) begin
            if (r_age_cnt != C_AGE_MAX) begin
                r_age_cnt <= r_age_cnt + 4'd1;
            end
        end else begin
            r_age_cnt <= 4'd0;
        end
    end
`else
    // Strict CPU priority: AGE_LIM is always 1..15, so this is constant 0.
    assign w_ext_force = ext_req && (C_AGE_MAX == 4'd0);
`endif

    // Grants are gated by reset so nothing is offered while the block is held.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ext_gnt = 1'b0;
        if (reset) begin
            if (r_state == ST_LOCK) begin
                w_ext_gnt = ext_req;
            end else if (w_ext_force) begin
                w_ext_gnt = 1'b1;
            end else if (cpu_req) begin
                w_cpu_gnt = 1'b1;
            end else begin
                w_ext_gnt = ext_req;
            end
        end
    end

    assign w_acc   = w_cpu_gnt || w_ext_gnt;
    assign w_wr    = w_ext_gnt ? ext_wr : cpu_wr;
    assign cpu_gnt = w_cpu_gnt;
    assign ext_gnt = w_ext_gnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_ARB;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r_s1_rd   <= 1'b0;
            r_s1_ext  <= 1'b0;
            r_s2_cpu  <= 1'b0;
            r_s2_ext  <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_ext_gnt && ext_lock) begin
                        r_state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (!ext_lock) begin
                        r_state <= ST_ARB;
                    end
                end
                default: r_state <= ST_ARB;
            endcase

            if (w_acc) begin
                mem_en    <= 1'b1;
                mem_we    <= w_wr;
                mem_addr  <= w_ext_gnt ? ext_addr  : cpu_addr;
                mem_wdata <= w_ext_gnt ? ext_wdata : cpu_wdata;
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end

            // Tag travels with the command, then lines up with RAM output data.
            r_s1_rd  <= w_acc && !w_wr;
            r_s1_ext <= w_ext_gnt;
            r_s2_cpu <= r_s1_rd && !r_s1_ext;
            r_s2_ext <= r_s1_rd && r_s1_ext;
        end
    end

    assign locked     = (r_state == ST_LOCK);
    assign cpu_rvalid = r_s2_cpu;
    assign ext_rvalid = r_s2_ext;
    assign cpu_rdata  = r_s2_cpu ? mem_rdata : '0;
    assign ext_rdata  = r_s2_ext ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed and random stimulus for mem_port_arbiter, compared
//               against a transaction-level reference model (grant rules,
//               model memory updated in grant order, queue of due reads).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW      = 5;
    localparam int DW      = 8;
    localparam int AGE_LIM = 4;
`ifdef MEM_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_wr, ext_req, ext_wr, ext_lock;
    logic [AW-1:0] cpu_addr, ext_addr;
    logic [DW-1:0] cpu_wdata, ext_wdata;
    logic          cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid;
    logic [DW-1:0] cpu_rdata, ext_rdata;
    logic          mem_en, mem_we, locked;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .AGE_LIM(AGE_LIM)) dut (
        .clock(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ext_req(ext_req), .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_lock(ext_lock),
        .cpu_gnt(cpu_gnt), .ext_gnt(ext_gnt),
        .cpu_rvalid(cpu_rvalid), .ext_rvalid(ext_rvalid),
        .cpu_rdata(cpu_rdata), .ext_rdata(ext_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .locked(locked)
    );

    // Single-port synchronous RAM macro
    logic [DW-1:0] ram [32];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model state
    typedef struct {
        int            due;
        bit            ext;
        logic [DW-1:0] data;
    } rd_t;
    rd_t           q[$];
    logic [DW-1:0] model_mem [32];
    bit            m_locked;
    int            m_denied;
    bit            exp_en, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    int            cyc;
    bit            last_cg, last_eg;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input bit er, input bit ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                        input bit el);
        bit            cg, eg, ecv, eev;
        logic [DW-1:0] ed_exp;
        rd_t           r;
        cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_wr = ew; ext_addr = ea; ext_wdata = ed; ext_lock = el;
        #1;
        chk("mem_en", mem_en, exp_en);
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wd);
        chk("locked", locked, m_locked);
        ecv = 0; eev = 0; ed_exp = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            ecv = !r.ext; eev = r.ext; ed_exp = r.data;
        end
        chk("cpu_rvalid", cpu_rvalid, ecv);
        chk("ext_rvalid", ext_rvalid, eev);
        chk("cpu_rdata", cpu_rdata, ecv ? ed_exp : '0);
        chk("ext_rdata", ext_rdata, eev ? ed_exp : '0);
        // Grant rules
        if (m_locked) begin
            cg = 0; eg = er;
        end else if (AGING && er && m_denied == AGE_LIM) begin
            cg = 0; eg = 1;
        end else begin
            cg = cr; eg = er && !cr;
        end
        chk("cpu_gnt", cpu_gnt, cg);
        chk("ext_gnt", ext_gnt, eg);
        last_cg = cg; last_eg = eg;
        // Effect of the accepted access
        if (cg || eg) begin
            exp_en   = 1;
            exp_we   = eg ? ew : cw;
            exp_addr = eg ? ea : ca;
            exp_wd   = eg ? ed : cd;
            if (exp_we) model_mem[exp_addr] = exp_wd;
            else q.push_back('{due: cyc + 2, ext: eg, data: model_mem[exp_addr]});
        end else begin
            exp_en = 0; exp_we = 0;
        end
        m_locked = m_locked ? el : (eg && el);
        if (er && !eg) begin
            if (m_denied < AGE_LIM) m_denied++;
        end else begin
            m_denied = 0;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, 0);
    endtask

    task automatic do_reset(input int ncyc);
        reset = 1'b0;
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_ext_gnt", ext_gnt, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_ext_rvalid", ext_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_ext_rdata", ext_rdata, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_locked", locked, 0);
        q.delete();
        m_locked = 0; m_denied = 0;
        exp_en = 0; exp_we = 0; exp_addr = '0; exp_wd = '0;
        repeat (ncyc) @(posedge clk);
        #1;
        cyc += ncyc;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ext;
        int n_cpu_lock;
        bit cp, ep, cr, er;
        reset = 1'b1;
        cyc = 0;
        cpu_req = 1; ext_req = 1; cpu_wr = 0; ext_wr = 0; ext_lock = 0;
        cpu_addr = '0; ext_addr = '0; cpu_wdata = '0; ext_wdata = '0;
        #2;
        // Reset held with both requests high, then CPU wins first
        do_reset(2);
        step(1, 0, 5'd0, 8'h00, 1, 0, 5'd1, 8'h00, 0);
        chk("first_gnt_cpu", last_cg, 1);
        idle(2);

        // Fill memory with known contents
        for (int a = 0; a < 32; a++) step(1, 1, 5'(a), 8'(a * 7 + 3), 0, 0, '0, '0, 0);
        idle(1);

        // CPU write then read-back of the same address
        step(1, 1, 5'd3, 8'h5A, 0, 0, '0, '0, 0);
        step(1, 0, 5'd3, 8'h00, 0, 0, '0, '0, 0);
        idle(3);
        chk("raw_model", model_mem[3], 8'h5A);

        // Continuous contention
        n_ext = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 5'(i), '0, 1, 0, 5'(i + 10), '0, 0);
            if (last_eg) n_ext++;
        end
        chk("aging_ext_wins", n_ext, AGING ? 2 : 0);
        idle(3);

        // Exclusive EXT ownership
        step(0, 0, '0, '0, 1, 0, 5'd7, '0, 1);
        n_cpu_lock = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 5'd4, '0, 1, 0, 5'd7, '0, 1);
            if (last_cg) n_cpu_lock++;
        end
        chk("lock_cpu_blocked", n_cpu_lock, 0);
        step(1, 0, 5'd4, '0, 0, 0, '0, '0, 0);
        step(1, 0, 5'd4, '0, 0, 0, '0, '0, 0);
        chk("unlock_cpu_gnt", last_cg, 1);
        idle(3);

        // Alternating owners
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 5'd1, '0, 0, 0, '0, '0, 0);
            step(0, 0, '0, '0, 1, 0, 5'd2, '0, 0);
        end
        idle(3);

        // Reset lands while a CPU read is in flight
        step(1, 0, 5'd5, '0, 0, 0, '0, '0, 0);
        cpu_req = 0;
        do_reset(1);
        idle(4);

        // Random traffic, requests held until granted
        cp = 0; ep = 0;
        for (int i = 0; i < 400; i++) begin
            cr = cp ? 1'b1 : ($urandom_range(0, 2) != 0);
            er = ep ? 1'b1 : ($urandom_range(0, 2) != 0);
            step(cr, 1'($urandom), 5'($urandom_range(0, 7)), 8'($urandom),
                 er, 1'($urandom), 5'($urandom_range(0, 7)), 8'($urandom),
                 $urandom_range(0, 7) == 0);
            cp = cr && !last_cg;
            ep = er && !last_eg;
        end
        idle(4);
        chk("drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single-port synchronous data/instruction memory between the control-unit datapath (CPU port) and an external loader/debug port (EXT port). Grants at most one access per clock, registers the memory command, and routes read data back to the owning requester with a one-bit tag pipeline. Sits between the control unit's memory interface (`Meminst`/`MemWr`-driven address and write paths) and the memory macro.

## Interface

Parameters:
- `AW`, 5, address width (32 words)
- `DW`, 8, data width
- `AGE_LIM`, 4, consecutive denied EXT cycles before EXT is forced to win (1..15)

Ports:
- `clock` in 1, single clock; all state updates on rising edge
- `reset` in 1, asynchronous, active-low; clears all state
- `cpu_req` / `ext_req` in 1, access request; held until granted
- `cpu_wr` / `ext_wr` in 1, 1 = write, 0 = read
- `cpu_addr` / `ext_addr` in AW, access address
- `cpu_wdata` / `ext_wdata` in DW, write data
- `ext_lock` in 1, EXT requests exclusive ownership after its next grant
- `cpu_gnt` / `ext_gnt` out 1, combinational; request accepted at the coming edge when req & gnt
- `cpu_rvalid` / `ext_rvalid` out 1, read data valid this cycle
- `cpu_rdata` / `ext_rdata` out DW, read data; equals `mem_rdata` when the port's rvalid is high, else 0
- `mem_en`, `mem_we` out 1, registered memory command
- `mem_addr` out AW, `mem_wdata` out DW, registered
- `mem_rdata` in DW, memory output, valid the cycle after the RAM edge that sampled `mem_en`
- `locked` out 1, high while in LOCK

## Operation

- FSM states: ARB (shared), LOCK (EXT exclusive).
- ARB: winner = CPU if `cpu_req`, else EXT if `ext_req`. Exception (aging): if `ext_req` and `age_cnt == AGE_LIM`, EXT wins over CPU.
- LOCK: `cpu_gnt` forced 0; `ext_gnt = ext_req`. Exit to ARB at the edge where `ext_lock` is sampled low (lock-drop cycle may still grant EXT).
- ARB -> LOCK at an edge where EXT is accepted with `ext_lock` high.
- Exactly one of `cpu_gnt`/`ext_gnt` high per cycle at most; gnt never high without matching req.
- On accept, next-cycle `mem_en`=1, `mem_we`=wr, `mem_addr`/`mem_wdata` = winner's values; no accept -> `mem_en`=0, `mem_we`=0, addr/wdata hold.
- Tag pipeline: stage 1 records {read, owner} with the command; stage 2 one cycle later drives the owner's rvalid. Writes produce no rvalid.
- `age_cnt` (4 bits): +1 each cycle `ext_req & !ext_gnt`, saturates at `AGE_LIM`; clears on EXT accept or `ext_req` low.
- Accesses complete in grant order; read-after-write to the same address returns the new data.

## Timing

- Reset values: all gnt/rvalid 0, rdata 0, `mem_en`/`mem_we` 0, `mem_addr`/`mem_wdata` 0, `locked` 0, state ARB, `age_cnt` 0, tag pipeline empty.
- Read latency: accept at edge E0 -> command on memory bus E0..E1 -> rvalid high for one cycle E1..E2. Two cycles accept-to-data.
- Throughput: one access per cycle, back-to-back, any mix of owners.
- Reset asserted mid-access: in-flight rvalid dropped, no later rvalid appears; memory command deasserted immediately (async).
- Requester changing addr/wr while req high and gnt low: latest values used at accept.

## Configuration

- `MEM_ARB_AGING_EN` defined: aging counter present, EXT forced to win at `AGE_LIM`.
- Not defined: `age_cnt` removed, strict CPU priority in ARB; EXT can starve under continuous `cpu_req`. LOCK behaviour unchanged.

## Test plan

- Reset: hold `reset`=0 with both reqs high -> all outputs 0; release -> CPU granted first cycle.
- CPU write 0x5A to addr 3, then CPU read addr 3 back-to-back -> `mem_we` 1 then 0, `cpu_rvalid` two cycles after read accept with `cpu_rdata`=0x5A, `ext_rvalid` stays 0.
- Both req continuous, `AGE_LIM`=4, aging on -> CPU granted 4 cycles, EXT on 5th, pattern repeats; macro off -> EXT never granted.
- EXT read with `ext_lock`=1 at addr 7 -> `locked`=1, `cpu_gnt`=0 for 6 cycles despite `cpu_req`; drop `ext_lock` -> ARB next cycle, CPU granted.
- Alternating owners reads addr 1 (CPU) / addr 2 (EXT) every cycle -> rvalids alternate, each carries its own address's data.
- Assert reset one cycle after a CPU read accept -> no `cpu_rvalid` ever for that read.
